// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the vga_fb framebuffer.
//   - 640x480 timing: horizontal 640/16/96/48, vertical 480/10/2/33
//   - framebuffer address width ({y,x}, 8+8 bits)
//   - write-buffer entry type {y[7:0], x[7:0], c[2:0]}
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;   // 525

    localparam int H_SYNC_START = H_ACTIVE + H_FRONT;                 // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;              // 752, exclusive
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT;                 // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;              // 492, exclusive

    // Only the first 512 columns are backed by the 256-wide framebuffer
    // (each stored pixel is shown as a 2x2 block).
    localparam int H_DISP = 512;

    localparam int FB_AW = 16;
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [2:0] c;
    } fifo_entry_t;

    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] y, input logic [7:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_fb_if.sv
// vga_fb_if: CPU pixel-write port of vga_fb.
//   vgax/vgay : pixel column/row       vgac : colour {r,g,b}
//   vgaw      : write strobe           full : buffer cannot accept a write
//   ovf       : sticky, a write was dropped
interface vga_fb_if;
    logic [7:0] vgax;
    logic [7:0] vgay;
    logic [2:0] vgac;
    logic       vgaw;
    logic       full;
    logic       ovf;

    modport master (output vgax, vgay, vgac, vgaw, input  full, ovf);
    modport slave  (input  vgax, vgay, vgac, vgaw, output full, ovf);
endinterface

// File: rtl/fb_fifo.sv
// fb_fifo: synchronous FIFO of pixel writes for vga_fb.
//   clk, reset (async, active-low)
//   push/din  : enqueue an entry (caller never pushes a full FIFO unless it pops too)
//   pop/dout  : dequeue the head; dout shows the head combinationally
//   full, empty, count : occupancy
// Simultaneous push and pop is legal when full: the head is read before the
// edge, and the new entry lands in the slot the head is vacating.
module fb_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fifo_entry_t            din,
    input  logic                   pop,
    output fifo_entry_t            dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: storage arrays are not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vga_fb.sv
// vga_fb: 640x480 VGA scan-out of a 256x240 3-bit framebuffer with a buffered
// CPU write port.
//   clk       : 25 MHz pixel clock
//   reset     : asynchronous, active-low
//   bus       : vga_fb_if.slave (vgax, vgay, vgac, vgaw -> full, ovf)
//   hsync     : horizontal sync, active-low
//   vsync     : vertical sync, active-low
//   rgb       : pixel colour to the DAC
// Parameter FIFO_DEPTH: write-buffer entries (power of two, >= 2).
// Macro VGA_FB_CLEAR_EN: when defined, a 65536-cycle sweep after reset writes
// 0 to every framebuffer address, holding full=1 and rgb=0 meanwhile.
// The single-port RAM is shared: buffered writes drain only in blanking, so
// active video always owns the read port.
module vga_fb
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    vga_fb_if.slave    bus,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic blank_now;
    logic dark_now;
    logic hs_now;
    logic vs_now;

    assign blank_now = !((h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE)));
    assign hs_now    = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
    assign vs_now    = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));

    logic             clearing;
    logic [FB_AW-1:0] clr_addr;

`ifdef VGA_FB_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clearing <= 1'b1;
            clr_addr <= '0;
        end else if (clearing) begin
            clr_addr <= clr_addr + 1'b1;
            if (&clr_addr) clearing <= 1'b0;
        end
    end
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // Columns 512..639 have no backing storage and are shown black.
    assign dark_now = blank_now || (h_cnt >= CNT_W'(H_DISP)) || clearing;

    fifo_entry_t   head;
    fifo_entry_t   wr_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          push;
    logic          drop;
    logic          ovf_q;

    // pop looks at the registered occupancy, so a fresh push never bypasses to RAM.
    assign pop  = blank_now && !fifo_empty && !clearing;
    // A same-cycle pop frees the slot, so a full buffer still accepts the write.
    assign push = bus.vgaw && !clearing && (!fifo_full || pop);
    assign drop = bus.vgaw && !push;

    assign wr_entry = '{y: bus.vgay, x: bus.vgax, c: bus.vgac};

    fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

    assign bus.ovf  = ovf_q;
    assign bus.full = (fifo_count == CW'(FIFO_DEPTH)) || clearing;

    logic [FB_AW-1:0] ram_addr;
    logic             ram_we;
    logic [2:0]       ram_wdata;
    logic [2:0]       ram_q;
    logic [2:0]       fb_mem [2**FB_AW];

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fb_addr(v_cnt[8:1], h_cnt[8:1]);
        ram_wdata = '0;
        if (clearing) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (pop) begin
            ram_we    = 1'b1;
            ram_addr  = fb_addr(head.y, head.x);
            ram_wdata = head.c;
        end
    end

    // Single port: exactly one read or one write per cycle.
    always_ff @(posedge clk) begin
        if (ram_we) fb_mem[ram_addr] <= ram_wdata;
        else        ram_q <= fb_mem[ram_addr];
    end

    // Two-stage video pipeline: stage 1 rides alongside the RAM read,
    // stage 2 is the output register.
    logic dark_d1;
    logic hs_d1;
    logic vs_d1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dark_d1 <= 1'b1;
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            rgb     <= '0;
        end else begin
            dark_d1 <= dark_now;
            hs_d1   <= hs_now;
            vs_d1   <= vs_now;
            hsync   <= hs_d1;
            vsync   <= vs_d1;
            rgb     <= dark_d1 ? 3'b000 : ram_q;
        end
    end

endmodule
